// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern,
// hex glyph table ({A,B,C,D,E,F,G}, active-high) and a lookup helper.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to seven-segment glyph decoder.
module seg7_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous
// value loading, leading-zero blanking, dead time and PWM brightness.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 8192,
  parameter int DEAD        = 64,
  parameter int BRIGHT_W    = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  LOAD,
  input  logic                  LZ_SUPPRESS,
  input  logic [BRIGHT_W-1:0]   BRIGHT,
  output logic [DIGITS-1:0]     DS_EN,
  output logic [6:0]            DS_SEG,
  output logic                  DS_DP,
  output logic                  FRAME_DONE
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, shad_val_q, shad_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q;

  logic                slot_end, frame_end, lit, upper_nonzero, blank;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic [6:0]          seg_dec;

  seg7_decoder u_dec (
    .nib_i (nib_sel),
    .seg_o (seg_dec)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;

    // A LOAD on the boundary cycle flows straight through pend_d into shadow.
    pend_val_d = LOAD ? VALUE : pend_val_q;
    pend_dp_d  = LOAD ? DP    : pend_dp_q;
    shad_val_d = frame_end ? pend_val_d : shad_val_q;
    shad_dp_d  = frame_end ? pend_dp_d  : shad_dp_q;

    nib_sel       = 4'h0;
    dp_sel        = 1'b0;
    upper_nonzero = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx_q == IDX_W'(j)) begin
        nib_sel = shad_val_q[j*4 +: 4];
        dp_sel  = shad_dp_q[j];
      end
      if ((IDX_W'(j) >= idx_q) && (shad_val_q[j*4 +: 4] != 4'h0)) upper_nonzero = 1'b1;
    end
    blank = LZ_SUPPRESS && (idx_q != '0) && !upper_nonzero;

    lit  = (cnt_q >= CNT_W'(DEAD)) && (cnt_q[BRIGHT_W-1:0] <= BRIGHT);
    en_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (lit) begin
      en_d[idx_q] = 1'b0;
      seg_d       = blank ? SEG_BLANK : seg_dec;
      dp_d        = dp_sel;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      en_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      en_q       <= en_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= frame_end;
    end
  end

  assign DS_EN      = en_q;
  assign DS_SEG     = seg_q;
  assign DS_DP      = dp_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle model feeding a scoreboard
// queue, plus directed per-frame observations against glyph constants.
module tb_seg_scan_driver;

  localparam int DIGITS = 4, REFRESH_DIV = 16, DEAD = 2, BRIGHT_W = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [15:0]   VALUE = '0;
  logic [3:0]    DP = '0;
  logic          LOAD = 1'b0;
  logic          LZ_SUPPRESS = 1'b0;
  logic [1:0]    BRIGHT = 2'd3;
  logic [3:0]    DS_EN;
  logic [6:0]    DS_SEG;
  logic          DS_DP;
  logic          FRAME_DONE;

  seg_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .DEAD(DEAD), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .DP(DP), .LOAD(LOAD),
    .LZ_SUPPRESS(LZ_SUPPRESS), .BRIGHT(BRIGHT), .DS_EN(DS_EN),
    .DS_SEG(DS_SEG), .DS_DP(DS_DP), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;  4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;  4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;  4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;  4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;  4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;  default: glyph = 7'b1000111;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  int          m_cnt = 0, m_idx = 0;
  logic [15:0] m_pval = '0, m_sval = '0;
  logic [3:0]  m_pdp = '0, m_sdp = '0;

  // Reference model: predicts the output registered on this edge from the
  // pre-edge slot position and shadow contents.
  always @(posedge CLK or posedge RST) begin
    exp_t e;
    logic bnd, on;
    if (RST) begin
      m_cnt = 0; m_idx = 0; m_pval = '0; m_sval = '0; m_pdp = '0; m_sdp = '0;
      exp_q.delete();
    end else begin
      bnd = (m_cnt == REFRESH_DIV - 1) && (m_idx == DIGITS - 1);
      on  = (m_cnt >= DEAD) && ((m_cnt % 4) <= int'(BRIGHT));
      e.en = 4'hF; e.seg = 7'h0; e.dp = 1'b0; e.fd = bnd;
      if (on) begin
        e.en[m_idx] = 1'b0;
        e.dp  = m_sdp[m_idx];
        e.seg = (LZ_SUPPRESS && m_idx > 0 && ((m_sval >> (4*m_idx)) == 16'h0))
                ? 7'h0 : glyph(4'((m_sval >> (4*m_idx)) & 16'hF));
      end
      exp_q.push_back(e);
      if (LOAD) begin m_pval = VALUE; m_pdp = DP; end
      if (bnd) begin m_sval = m_pval; m_sdp = m_pdp; end
      m_cnt = m_cnt + 1;
      if (m_cnt == REFRESH_DIV) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_en",  32'(DS_EN),      32'(e.en));
      chk("sb_seg", 32'(DS_SEG),     32'(e.seg));
      chk("sb_dp",  32'(DS_DP),      32'(e.dp));
      chk("sb_fd",  32'(FRAME_DONE), 32'(e.fd));
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    VALUE = v; DP = d; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic wait_fd();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (FRAME_DONE) break;
    end
    if (k == 200) chk("fd_timeout", 32'd0, 32'd1);
  endtask

  // Samples one full frame and checks per-digit glyph, DP and lit count.
  task automatic observe_frame(input string tag, input logic [3:0][6:0] es,
                               input logic [3:0] edp, input int elit);
    int lit_n[4];
    logic [6:0] s_or[4], s_and[4];
    logic [3:0] dp_or;
    int dark_bad, en_bad, fd_n, hit;
    dark_bad = 0; en_bad = 0; fd_n = 0; dp_or = '0;
    for (int d = 0; d < 4; d++) begin lit_n[d] = 0; s_or[d] = '0; s_and[d] = '1; end
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      fd_n += int'(FRAME_DONE);
      if (DS_EN == 4'hF) begin
        if (DS_SEG != 7'h0 || DS_DP) dark_bad++;
      end else begin
        hit = 0;
        for (int d = 0; d < 4; d++)
          if (DS_EN == ~(4'b0001 << d)) begin
            hit = 1; lit_n[d]++;
            s_or[d] |= DS_SEG; s_and[d] &= DS_SEG; dp_or[d] |= DS_DP;
          end
        if (hit == 0) en_bad++;
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk({tag, "_lit"},  32'(lit_n[d]), 32'(elit));
      chk({tag, "_sor"},  32'(s_or[d]),  32'(es[d]));
      chk({tag, "_sand"}, 32'(s_and[d]), 32'(es[d]));
    end
    chk({tag, "_dp"},   32'(dp_or),    32'(edp));
    chk({tag, "_dark"}, 32'(dark_bad), 32'd0);
    chk({tag, "_en"},   32'(en_bad),   32'd0);
    chk({tag, "_fd"},   32'(fd_n),     32'd1);
  endtask

  initial begin
    int tear, k;
    #2 RST = 1'b1;
    #1;
    chk("rst_en", 32'(DS_EN), 32'hF);
    chk("rst_seg", 32'(DS_SEG), 32'h0);
    chk("rst_dp", 32'(DS_DP), 32'h0);
    chk("rst_fd", 32'(FRAME_DONE), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    BRIGHT = 2'd3;
    do_load(16'h12AF, 4'h0);
    wait_fd();
    observe_frame("hex12af", {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}, 4'h0, 14);

    BRIGHT = 2'd0;
    do_load(16'h8888, 4'h0);
    wait_fd();
    observe_frame("dim8888", {4{7'b1111111}}, 4'h0, 3);

    BRIGHT = 2'd3; LZ_SUPPRESS = 1'b1;
    do_load(16'h0050, 4'b1000);
    wait_fd();
    observe_frame("lz0050", {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b1000, 14);
    do_load(16'h0000, 4'h0);
    wait_fd();
    observe_frame("lz0000", {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'h0, 14);

    LZ_SUPPRESS = 1'b0;
    wait_fd();
    repeat (20) @(negedge CLK);
    do_load(16'h1111, 4'h0);
    tear = 0;
    for (k = 0; k < 200; k++) begin
      if (DS_SEG == 7'b0110000) tear++;
      if (FRAME_DONE) break;
      @(negedge CLK);
    end
    chk("no_tear", 32'(tear), 32'd0);
    chk("tear_fd_seen", 32'(FRAME_DONE), 32'd1);
    observe_frame("mid1111", {4{7'b0110000}}, 4'h0, 14);

    wait_fd();
    repeat (63) @(negedge CLK);
    VALUE = 16'h3333; DP = 4'h0; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    chk("bnd_fd", 32'(FRAME_DONE), 32'd1);
    observe_frame("bnd3333", {4{7'b1111001}}, 4'h0, 14);
    observe_frame("hold3333", {4{7'b1111001}}, 4'h0, 14);

    wait_fd();
    repeat (5) @(negedge CLK);
    do_load(16'h4444, 4'h0);
    repeat (5) @(negedge CLK);
    do_load(16'h5555, 4'h0);
    wait_fd();
    observe_frame("last5555", {4{7'b1011011}}, 4'h0, 14);

    for (k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (DS_EN != 4'hF) break;
    end
    chk("pre_rst_lit", 32'(DS_EN != 4'hF), 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_en", 32'(DS_EN), 32'hF);
    chk("mid_rst_seg", 32'(DS_SEG), 32'h0);
    chk("mid_rst_dp", 32'(DS_DP), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int c = 1; c <= DEAD + 1; c++) begin
      @(negedge CLK);
      chk("first_lit_en", 32'(DS_EN), (c == DEAD + 1) ? 32'hE : 32'hF);
      chk("first_lit_seg", 32'(DS_SEG), (c == DEAD + 1) ? 32'h7E : 32'h0);
    end
    repeat (20) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
